// File: rtl/mw_writeback_stage.sv
// Memory/writeback pipeline latch with register-file write decode, a forwarding tap
// and a retirement counter.
module mw_writeback_stage (
    input  logic        clock,
    input  logic        reset,
    input  logic        stall,
    input  logic        flush,
    input  logic        in_valid,
    input  logic [31:0] in_instruction,
    input  logic [31:0] in_alu_result,
    input  logic [31:0] in_mem_data,
    input  logic [31:0] in_pc_plus1,
    output logic        reg_write_enable,
    output logic [4:0]  reg_write_addr,
    output logic [31:0] reg_write_data,
    output logic        bypass_valid,
    output logic [4:0]  bypass_addr,
    output logic [31:0] bypass_data,
    output logic [15:0] retired_count
);

    localparam logic [4:0] OP_RTYPE = 5'b00000;
    localparam logic [4:0] OP_ADDI  = 5'b00101;
    localparam logic [4:0] OP_LW    = 5'b01000;
    localparam logic [4:0] OP_JAL   = 5'b00011;
    localparam logic [4:0] LINK_REG = 5'd31;

    logic        r_vld_p0;
    logic [31:0] r_instr_p0;
    logic [31:0] r_alu_p0;
    logic [31:0] r_mem_p0;
    logic [31:0] r_pc1_p0;
    logic [15:0] r_count;

    logic [4:0]  w_opcode;
    logic [4:0]  w_rd;
    logic        w_writes;
    logic [4:0]  w_addr;
    logic [31:0] w_data;
    logic        w_bypass_valid;
    logic        w_unused;

    // Stage boundary: memory -> writeback latch
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_vld_p0   <= 1'b0;
            r_instr_p0 <= '0;
            r_alu_p0   <= '0;
            r_mem_p0   <= '0;
            r_pc1_p0   <= '0;
        end else if (flush) begin
            r_vld_p0 <= 1'b0;
        end else if (!stall) begin
            r_vld_p0   <= in_valid;
            r_instr_p0 <= in_instruction;
            r_alu_p0   <= in_alu_result;
            r_mem_p0   <= in_mem_data;
            r_pc1_p0   <= in_pc_plus1;
        end
    end

    // Retirement is judged on the instruction leaving the latch, so flush has no say here.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (r_vld_p0 && !stall) begin
            r_count <= r_count + 16'd1;
        end
    end

    always_comb begin
        w_opcode = r_instr_p0[31:27];
        w_rd     = r_instr_p0[26:22];
        w_writes = 1'b0;
        w_addr   = w_rd;
        w_data   = r_alu_p0;
        case (w_opcode)
            OP_RTYPE, OP_ADDI: w_writes = 1'b1;
            OP_LW: begin
                w_writes = 1'b1;
                w_data   = r_mem_p0;
            end
            OP_JAL: begin
                w_writes = 1'b1;
                w_addr   = LINK_REG;
                w_data   = r_pc1_p0;
            end
            default: w_writes = 1'b0;
        endcase
    end

    assign w_bypass_valid   = r_vld_p0 && w_writes && (w_addr != 5'd0);
    assign w_unused         = ^r_instr_p0[21:0];

    assign bypass_valid     = w_bypass_valid;
    assign bypass_addr      = w_addr;
    assign bypass_data      = w_data;
    // A stalled instruction stays visible for forwarding but writes only when it leaves.
    assign reg_write_enable = w_bypass_valid && !stall;
    assign reg_write_addr   = w_addr;
    assign reg_write_data   = w_data;
    assign retired_count    = r_count;

endmodule

// File: tb/tb_mw_writeback_stage.sv
// Self-checking bench for mw_writeback_stage: directed scenarios plus randomized traffic
// against a behavioural model of the writeback rules.
module tb_mw_writeback_stage;

    logic        clock = 1'b0;
    logic        reset, stall, flush, in_valid;
    logic [31:0] in_instruction, in_alu_result, in_mem_data, in_pc_plus1;
    logic        reg_write_enable, bypass_valid;
    logic [4:0]  reg_write_addr, bypass_addr;
    logic [31:0] reg_write_data, bypass_data;
    logic [15:0] retired_count;

    int errors = 0;
    int checks = 0;

    // Model state: the instruction currently held, and the number of retirements.
    bit          mv;
    logic [31:0] mi, ma, mm, mp;
    logic [15:0] mcnt;

    mw_writeback_stage dut (
        .clock(clock), .reset(reset), .stall(stall), .flush(flush),
        .in_valid(in_valid), .in_instruction(in_instruction),
        .in_alu_result(in_alu_result), .in_mem_data(in_mem_data),
        .in_pc_plus1(in_pc_plus1),
        .reg_write_enable(reg_write_enable), .reg_write_addr(reg_write_addr),
        .reg_write_data(reg_write_data), .bypass_valid(bypass_valid),
        .bypass_addr(bypass_addr), .bypass_data(bypass_data),
        .retired_count(retired_count)
    );

    always #5 clock = ~clock;

    function automatic bit m_writes(input logic [31:0] i);
        logic [4:0] op;
        op = i[31:27];
        return op inside {5'd0, 5'd5, 5'd8, 5'd3};
    endfunction

    function automatic logic [4:0] m_addr(input logic [31:0] i);
        return (i[31:27] == 5'd3) ? 5'd31 : i[26:22];
    endfunction

    function automatic logic [31:0] m_data();
        if (mi[31:27] == 5'd8) return mm;
        if (mi[31:27] == 5'd3) return mp;
        return ma;
    endfunction

    function automatic bit m_bv();
        return mv && m_writes(mi) && (m_addr(mi) != 5'd0);
    endfunction

    task automatic model_reset();
        mv = 0; mi = '0; ma = '0; mm = '0; mp = '0; mcnt = '0;
    endtask

    task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] alu,
                         input logic [31:0] mem, input logic [31:0] pc1);
        in_valid = v; in_instruction = ins; in_alu_result = alu;
        in_mem_data = mem; in_pc_plus1 = pc1;
    endtask

    // Advance one clock edge, applying the stage rules to the model first.
    task automatic tick();
        if (mv && !stall) mcnt = mcnt + 16'd1;
        if (flush) mv = 0;
        else if (!stall) begin
            mv = in_valid; mi = in_instruction; ma = in_alu_result;
            mm = in_mem_data; mp = in_pc_plus1;
        end
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        stall = 0; flush = 0;
        drive(0, 0, 0, 0, 0);
        do_reset();
        checks++; if (retired_count !== 16'd0) begin errors++; $display("FAIL reset_count_init: got %h expected 0000", retired_count); end
        drive(1, 32'h0140_0000, 32'h5555, 32'h6666, 32'h7777);
        tick(); tick(); tick();
        checks++; if (reg_write_enable !== 1'b1) begin errors++; $display("FAIL reset_preload_en: got %b expected 1", reg_write_enable); end
        checks++; if (retired_count !== 16'd2) begin errors++; $display("FAIL reset_preload_count: got %h expected 0002", retired_count); end
        #2 reset = 1'b1;
        #1;
        checks++; if (reg_write_enable !== 1'b0) begin errors++; $display("FAIL reset_en: got %b expected 0", reg_write_enable); end
        checks++; if (bypass_valid !== 1'b0) begin errors++; $display("FAIL reset_bv: got %b expected 0", bypass_valid); end
        checks++; if (reg_write_addr !== 5'd0) begin errors++; $display("FAIL reset_addr: got %0d expected 0", reg_write_addr); end
        checks++; if (reg_write_data !== 32'd0) begin errors++; $display("FAIL reset_data: got %h expected 0", reg_write_data); end
        checks++; if (retired_count !== 16'd0) begin errors++; $display("FAIL reset_count: got %h expected 0000", retired_count); end
        drive(0, 0, 0, 0, 0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_rtype();
        logic [15:0] c0;
        c0 = mcnt;
        drive(1, 32'h0140_0000, 32'h0000_1234, $urandom, $urandom);
        tick();
        checks++; if (reg_write_enable !== 1'b1) begin errors++; $display("FAIL rtype_en: got %b expected 1", reg_write_enable); end
        checks++; if (reg_write_addr !== 5'd5) begin errors++; $display("FAIL rtype_addr: got %0d expected 5", reg_write_addr); end
        checks++; if (reg_write_data !== 32'h1234) begin errors++; $display("FAIL rtype_data: got %h expected 00001234", reg_write_data); end
        checks++; if (bypass_addr !== 5'd5 || bypass_data !== 32'h1234) begin errors++; $display("FAIL rtype_bypass: got %0d/%h expected 5/00001234", bypass_addr, bypass_data); end
        checks++; if (retired_count !== c0) begin errors++; $display("FAIL rtype_count_before: got %h expected %h", retired_count, c0); end
        drive(0, 0, 0, 0, 0);
        tick();
        checks++; if (retired_count !== c0 + 16'd1) begin errors++; $display("FAIL rtype_count_after: got %h expected %h", retired_count, c0 + 16'd1); end
    endtask

    task automatic test_lw_jal();
        drive(1, 32'h40C0_0000, $urandom, 32'h0000_CAFE, $urandom);
        tick();
        checks++; if (reg_write_enable !== 1'b1 || reg_write_addr !== 5'd3) begin errors++; $display("FAIL lw_addr: got en=%b addr=%0d expected en=1 addr=3", reg_write_enable, reg_write_addr); end
        checks++; if (reg_write_data !== 32'hCAFE) begin errors++; $display("FAIL lw_data: got %h expected 0000cafe", reg_write_data); end
        drive(1, 32'h1800_0000, $urandom, $urandom, 32'h0000_0040);
        tick();
        checks++; if (reg_write_enable !== 1'b1 || reg_write_addr !== 5'd31) begin errors++; $display("FAIL jal_addr: got en=%b addr=%0d expected en=1 addr=31", reg_write_enable, reg_write_addr); end
        checks++; if (reg_write_data !== 32'h40) begin errors++; $display("FAIL jal_data: got %h expected 00000040", reg_write_data); end
        drive(0, 0, 0, 0, 0);
        tick();
    endtask

    task automatic test_suppress();
        logic [15:0] c0;
        c0 = mcnt;
        drive(1, 32'h2800_0000, $urandom, $urandom, $urandom);
        tick();
        checks++; if (reg_write_enable !== 1'b0 || bypass_valid !== 1'b0) begin errors++; $display("FAIL addi_r0: got en=%b bv=%b expected 0/0", reg_write_enable, bypass_valid); end
        drive(1, 32'h3800_0000, $urandom, $urandom, $urandom);
        tick();
        checks++; if (reg_write_enable !== 1'b0 || bypass_valid !== 1'b0) begin errors++; $display("FAIL sw_nowrite: got en=%b bv=%b expected 0/0", reg_write_enable, bypass_valid); end
        drive(0, 0, 0, 0, 0);
        tick();
        checks++; if (retired_count !== c0 + 16'd2) begin errors++; $display("FAIL suppress_count: got %h expected %h", retired_count, c0 + 16'd2); end
    endtask

    task automatic test_stall_flush();
        logic [15:0] c0;
        int writes;
        drive(1, 32'h0140_0000, 32'h0000_ABCD, 0, 0);
        tick();
        c0 = mcnt;
        writes = 0;
        stall = 1;
        drive(1, 32'h0080_0000, 32'h9999, 0, 0);
        #1;
        for (int k = 0; k < 3; k++) begin
            checks++; if (reg_write_enable !== 1'b0 || bypass_valid !== 1'b1) begin errors++; $display("FAIL stall_hold[%0d]: got en=%b bv=%b expected 0/1", k, reg_write_enable, bypass_valid); end
            checks++; if (bypass_addr !== 5'd5 || retired_count !== c0) begin errors++; $display("FAIL stall_state[%0d]: got addr=%0d cnt=%h expected 5/%h", k, bypass_addr, retired_count, c0); end
            tick();
        end
        stall = 0;
        drive(0, 0, 0, 0, 0);
        #1;
        if (reg_write_enable === 1'b1) writes++;
        tick();
        if (reg_write_enable === 1'b1) writes++;
        checks++; if (writes !== 1) begin errors++; $display("FAIL stall_release_writes: got %0d expected 1", writes); end
        checks++; if (retired_count !== c0 + 16'd1) begin errors++; $display("FAIL stall_release_count: got %h expected %h", retired_count, c0 + 16'd1); end

        drive(1, 32'h29C0_0000, 32'h77, 0, 0);
        tick();
        c0 = mcnt;
        stall = 1; flush = 1;
        tick();
        checks++; if (bypass_valid !== 1'b0 || reg_write_enable !== 1'b0) begin errors++; $display("FAIL stallflush_empty: got en=%b bv=%b expected 0/0", reg_write_enable, bypass_valid); end
        checks++; if (retired_count !== c0) begin errors++; $display("FAIL stallflush_count: got %h expected %h", retired_count, c0); end
        stall = 0; flush = 0;
        drive(0, 0, 0, 0, 0);
        tick();
        checks++; if (retired_count !== c0) begin errors++; $display("FAIL stallflush_after: got %h expected %h", retired_count, c0); end

        drive(1, 32'h0140_0000, 32'h1111, 0, 0);
        tick();
        stall = 1;
        drive(0, 0, 0, 0, 0);
        tick();
        #2 reset = 1'b1;
        #1;
        checks++; if (reg_write_enable !== 1'b0 || bypass_valid !== 1'b0) begin errors++; $display("FAIL reset_midstall: got en=%b bv=%b expected 0/0", reg_write_enable, bypass_valid); end
        @(posedge clock);
        #1;
        reset = 1'b0; stall = 0;
        model_reset();
        tick();
        checks++; if (reg_write_enable !== 1'b0 || retired_count !== 16'd0) begin errors++; $display("FAIL reset_midstall_after: got en=%b cnt=%h expected 0/0000", reg_write_enable, retired_count); end
    endtask

    task automatic test_random();
        logic [4:0] ops [6];
        logic [4:0] rd;
        ops[0] = 5'd0; ops[1] = 5'd5; ops[2] = 5'd8; ops[3] = 5'd3; ops[4] = 5'd7; ops[5] = 5'd12;
        for (int n = 0; n < 400; n++) begin
            stall = ($urandom_range(0, 3) == 0);
            flush = ($urandom_range(0, 5) == 0);
            rd = ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom);
            drive($urandom_range(0, 3) != 0, {ops[$urandom_range(0, 5)], rd, 22'($urandom)},
                  $urandom, $urandom, $urandom);
            tick();
            checks++; if (bypass_valid !== m_bv()) begin errors++; $display("FAIL rand_bv[%0d]: got %b expected %b", n, bypass_valid, m_bv()); end
            checks++; if (reg_write_enable !== (m_bv() && !stall)) begin errors++; $display("FAIL rand_en[%0d]: got %b expected %b", n, reg_write_enable, m_bv() && !stall); end
            checks++; if (retired_count !== mcnt) begin errors++; $display("FAIL rand_count[%0d]: got %h expected %h", n, retired_count, mcnt); end
            if (mv) begin
                checks++; if (reg_write_addr !== m_addr(mi) || bypass_addr !== m_addr(mi)) begin errors++; $display("FAIL rand_addr[%0d]: got %0d/%0d expected %0d", n, reg_write_addr, bypass_addr, m_addr(mi)); end
                checks++; if (reg_write_data !== m_data() || bypass_data !== m_data()) begin errors++; $display("FAIL rand_data[%0d]: got %h/%h expected %h", n, reg_write_data, bypass_data, m_data()); end
            end
        end
        stall = 0; flush = 0;
        drive(0, 0, 0, 0, 0);
    endtask

    task automatic test_wrap();
        stall = 0; flush = 0;
        drive(0, 0, 0, 0, 0);
        do_reset();
        drive(1, 32'h0140_0000, 32'h1, 0, 0);
        for (int n = 0; n < 65536; n++) tick();
        checks++; if (retired_count !== 16'hFFFF) begin errors++; $display("FAIL wrap_max: got %h expected ffff", retired_count); end
        tick();
        checks++; if (retired_count !== 16'h0000) begin errors++; $display("FAIL wrap_zero: got %h expected 0000", retired_count); end
        checks++; if (retired_count !== mcnt) begin errors++; $display("FAIL wrap_model: got %h expected %h", retired_count, mcnt); end
    endtask

    initial begin
        reset = 1'b1; stall = 0; flush = 0;
        drive(0, 0, 0, 0, 0);
        model_reset();
        #3;
        test_reset();
        test_rtype();
        test_lw_jal();
        test_suppress();
        test_stall_flush();
        test_random();
        test_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
